uart_tx_sched: RTL and testbench

Two-requester transmit scheduler for the UART transmit path. Arbitrates byte requests from two sources (round-robin) into an internal FIFO and generates the baud-bit timing from the system clock. Serialises each byte as an 8N1 frame, LSB first. Sits between the on-chip producers (e.g. CPU mailbox, debug logger) and the UART TX pin, so producers never have to handle the baud-rate clock directly.

---
 rtl/uart_tx_sched_if.sv | 22 ++
 rtl/uart_tx_sched.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Request-side bundle for uart_tx_sched: two byte producers and the one-hot grant.
// master = producer side, slave = scheduler side.
interface uart_tx_sched_if;
  logic [1:0] iREQ_VALID;
  logic [7:0] iREQ_DATA0;
  logic [7:0] iREQ_DATA1;
  logic [1:0] oREQ_READY;

  modport master (
    output iREQ_VALID,
    output iREQ_DATA0,
    output iREQ_DATA1,
    input  oREQ_READY
  );

  modport slave (
    input  iREQ_VALID,
    input  iREQ_DATA0,
    input  iREQ_DATA1,
    output oREQ_READY
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmit scheduler: round-robin arbiter feeding a small FIFO,
// baud-rate generator and 8N1 serialiser (LSB first, line idles high).
// Optional macro UART_TX_SCHED_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_sched #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_sched_if.slave       req_if,
  output logic                 oTX_DATA,
  output logic                 oBUSY,
  output logic [FIFO_AW:0]     oFIFO_COUNT
);

  localparam int unsigned      Depth    = 2 ** FIFO_AW;
  localparam logic [15:0]      BaudMax  = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] DepthCnt = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_SCHED_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e             r_state;
  logic [15:0]        r_baud;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic [7:0]         r_mem [Depth];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_rr_ptr;   // requester favoured when both are valid

  logic [1:0]         w_grant;
  logic               w_push;
  logic [7:0]         w_push_data;
  logic               w_pop;
  logic               w_tick;
  logic               w_not_full;

  assign w_not_full  = (r_count < DepthCnt);
  assign w_push      = |w_grant;
  assign w_push_data = w_grant[1] ? req_if.iREQ_DATA1 : req_if.iREQ_DATA0;
  assign w_pop       = (r_state == StIdle) && (r_count != '0);
  assign w_tick      = (r_baud == BaudMax);

  // Grant from registered occupancy only; a same-cycle pop does not open a slot.
  always_comb begin
    w_grant = 2'b00;
    if (w_not_full) begin
      unique case (req_if.iREQ_VALID)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign req_if.oREQ_READY = w_grant;

  // FIFO storage; contents need no reset because occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // FIFO pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= w_grant[0];  // favour the requester that was not just served
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM: baud counter, bit index, shift register and registered line output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      if (r_state != StIdle) r_baud <= w_tick ? 16'd0 : r_baud + 16'd1;
      unique case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_state   <= StStart;
          end
        end
        StStart: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= StData;
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
              r_tx    <= ^r_shift;
              r_state <= StParity;
`else
              r_tx    <= 1'b1;
              r_state <= StStop;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[r_bit_idx + 3'd1];
            end
          end
        end
`ifdef UART_TX_SCHED_PARITY_EN
        StParity: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= StStop;
          end
        end
`endif
        StStop: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign oTX_DATA    = r_tx;
  assign oBUSY       = (r_state != StIdle) | (r_count != '0);
  assign oFIFO_COUNT = r_count;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with CLK_DIV=4, FIFO depth 8.
module tb_uart_tx_sched;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FIFO_AW = 3;
`ifdef UART_TX_SCHED_PARITY_EN
  localparam int unsigned FRAME = 11 * CLK_DIV;
`else
  localparam int unsigned FRAME = 10 * CLK_DIV;
`endif
  localparam int unsigned NBITS = FRAME / CLK_DIV;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tx_data;
  logic             busy;
  logic [FIFO_AW:0] fifo_count;
  int               n_cmp = 0;
  int               n_fail = 0;
  int               cyc = 0;
  logic [7:0]       rx_q[$];
  logic             par_q[$];
  int               st_q[$];

  uart_tx_sched_if req_if ();

  uart_tx_sched #(
    .CLK_DIV(CLK_DIV),
    .FIFO_AW(FIFO_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_if     (req_if),
    .oTX_DATA   (tx_data),
    .oBUSY      (busy),
    .oFIFO_COUNT(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent line receiver: samples mid-bit, records start cycle, byte and parity.
  initial begin : rx
    logic [7:0] b;
    logic       p;
    b = '0;
    p = 1'b0;
    forever begin
      @(negedge tx_data);
      #1;
      st_q.push_back(cyc);
      repeat (CLK_DIV / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(posedge clk);
        b[i] = tx_data;
      end
`ifdef UART_TX_SCHED_PARITY_EN
      repeat (CLK_DIV) @(posedge clk);
      p = tx_data;
      par_q.push_back(p);
`endif
      repeat (CLK_DIV) @(posedge clk);
      rx_q.push_back(b);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 20000 cycles");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 2000) begin
      step(1);
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Push one byte from requester 0 and count clocks from start bit to oBUSY low.
  task automatic send_measure(input logic [7:0] b, input string tag);
    int k;
    int len;
    k = 0;
    len = 0;
    req_if.iREQ_DATA0 = b;
    req_if.iREQ_VALID = 2'b01;
    step(1);
    req_if.iREQ_VALID = 2'b00;
    while (tx_data !== 1'b0 && k < 20) begin
      step(1);
      k++;
    end
    while (busy !== 1'b0 && len < 200) begin
      step(1);
      len++;
    end
    chk(tag, 32'(len), 32'(FRAME));
  endtask

  initial begin : stim
    logic [10:0] fr;
    req_if.iREQ_VALID = 2'b00;
    req_if.iREQ_DATA0 = 8'h00;
    req_if.iREQ_DATA1 = 8'h00;

    // Reset state
    step(3);
    chk("rst_tx", 32'(tx_data), 32'd1);
    chk("rst_ready", 32'(req_if.oREQ_READY), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step(2);
    chk("rel_tx", 32'(tx_data), 32'd1);
    chk("rel_ready", 32'(req_if.oREQ_READY), 32'd0);

    // Single byte 0xA5 from requester 0, bit-by-bit line check
    req_if.iREQ_DATA0 = 8'hA5;
    req_if.iREQ_VALID = 2'b01;
    #1;
    chk("t2_grant", 32'(req_if.oREQ_READY), 32'd1);
    step(1);
    req_if.iREQ_VALID = 2'b00;
    chk("t2_count_push", 32'(fifo_count), 32'd1);
    chk("t2_tx_pop_cycle", 32'(tx_data), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    step(1);
    chk("t2_count_pop", 32'(fifo_count), 32'd0);
`ifdef UART_TX_SCHED_PARITY_EN
    fr = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    fr = {1'b1, 1'b1, 8'hA5, 1'b0};
`endif
    for (int b = 0; b < int'(NBITS); b++) begin
      for (int c = 0; c < int'(CLK_DIV); c++) begin
        chk($sformatf("t2_bit%0d_c%0d", b, c), 32'(tx_data), 32'(fr[b]));
        step(1);
      end
    end
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_tx_end", 32'(tx_data), 32'd1);

    // Reset asserted mid-frame (during start bit with 2 bytes queued)
    req_if.iREQ_DATA0 = 8'h5A;
    req_if.iREQ_VALID = 2'b01;
    step(3);
    req_if.iREQ_VALID = 2'b00;
    chk("t1_count_before", 32'(fifo_count), 32'd2);
    chk("t1_tx_low_before", 32'(tx_data), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_tx_abort", 32'(tx_data), 32'd1);
    chk("t1_count_abort", 32'(fifo_count), 32'd0);
    chk("t1_busy_abort", 32'(busy), 32'd0);
    step(50);
    reset = 1'b1;
    step(1);
    chk("t1_tx_after", 32'(tx_data), 32'd1);

    // Both requesters valid: alternating grants, then FIFO fill to 8
    rx_q.delete();
    st_q.delete();
    req_if.iREQ_DATA0 = 8'h11;
    req_if.iREQ_DATA1 = 8'h22;
    req_if.iREQ_VALID = 2'b11;
    #1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t3_grant%0d", k), 32'(req_if.oREQ_READY), (k % 2 == 0) ? 32'd1 : 32'd2);
      step(1);
    end
    chk("t4_count_full", 32'(fifo_count), 32'd8);
    chk("t4_ready_full", 32'(req_if.oREQ_READY), 32'd0);
    step(FRAME - 7);
    chk("t4_still_full", 32'(fifo_count), 32'd8);
    chk("t4_ready_still0", 32'(req_if.oREQ_READY), 32'd0);
    chk("t4_idle_gap", 32'(tx_data), 32'd1);
    step(1);
    chk("t4_count_pop", 32'(fifo_count), 32'd7);
    chk("t4_ready_back", 32'(req_if.oREQ_READY), 32'd2);
    chk("t4_next_start", 32'(tx_data), 32'd0);
    step(1);
    req_if.iREQ_VALID = 2'b00;
    chk("t4_count_refill", 32'(fifo_count), 32'd8);
    wait_idle("t3_drain");
    chk("t3_nframes", 32'(rx_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      chk($sformatf("t3_byte%0d", i), 32'(rx_q[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
    end

    // Two back-to-back bytes: start-to-start spacing is one frame plus one clock
    step(2);
    rx_q.delete();
    st_q.delete();
    req_if.iREQ_DATA0 = 8'h3C;
    req_if.iREQ_VALID = 2'b01;
    step(1);
    req_if.iREQ_DATA0 = 8'hC3;
    step(1);
    req_if.iREQ_VALID = 2'b00;
    chk("t5_count", 32'(fifo_count), 32'd1);
    wait_idle("t5_drain");
    chk("t5_nstarts", 32'(st_q.size()), 32'd2);
    if (st_q.size() >= 2) chk("t5_spacing", 32'(st_q[1] - st_q[0]), 32'(FRAME + 1));
    if (rx_q.size() >= 2) begin
      chk("t5_byte0", 32'(rx_q[0]), 32'h3C);
      chk("t5_byte1", 32'(rx_q[1]), 32'hC3);
    end

    // Single-frame length and parity bit
    step(2);
    rx_q.delete();
    par_q.delete();
    send_measure(8'h07, "t6_len_07");
    step(2);
    send_measure(8'h03, "t6_len_03");
    step(2);
    chk("t6_nframes", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 2) begin
      chk("t6_byte0", 32'(rx_q[0]), 32'h07);
      chk("t6_byte1", 32'(rx_q[1]), 32'h03);
    end
`ifdef UART_TX_SCHED_PARITY_EN
    chk("t6_npar", 32'(par_q.size()), 32'd2);
    if (par_q.size() >= 2) begin
      chk("t6_par_07", 32'(par_q[0]), 32'd1);
      chk("t6_par_03", 32'(par_q[1]), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
